clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_cfg_shadow.sv | 51 +++++
 rtl/clk_div_prog.sv | 120 ++++++++++++
 tb/tb_clk_div_prog.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared state encoding and default sizing for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned CntWDefault    = 23;
    localparam int unsigned DefHalfDefault = 5_000_000;

    typedef enum logic [1:0] {
        StStop,
        StRunLo,
        StRunHi
    } state_e;

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// Shadow register for the divider half-period: valid/ready capture, zero clamp, and a
// pending flag that the state machine clears when it takes the new value.
module clk_div_cfg_shadow
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CntWDefault,
    parameter int unsigned DEF_HALF = DefHalfDefault
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             apply,
    output logic             cfg_ready,
    output logic             pending,
    output logic [CNT_W-1:0] shadow_half
);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             accept;

    // Only one update can be outstanding; offers while pending are dropped.
    assign accept = cfg_valid && !pending_q;

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (accept) begin
            shadow_d  = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            shadow_q  <= CNT_W'(DEF_HALF);
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign cfg_ready   = !pending_q;
    assign pending     = pending_q;
    assign shadow_half = shadow_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable 50 % duty clock divider with glitch-free half-period updates.
// Define CLK_DIV_TICK_EN to add a one-cycle tick output on each rising edge of clk_out.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CntWDefault,
    parameter int unsigned DEF_HALF = DefHalfDefault
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             pending
`ifdef CLK_DIV_TICK_EN
    ,
    output logic             tick
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shadow_half;
    logic             clk_out_q;
    logic             apply;
    logic             terminal;

    clk_div_cfg_shadow #(
        .CNT_W   (CNT_W),
        .DEF_HALF(DEF_HALF)
    ) u_cfg_shadow (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_half   (cfg_half),
        .apply      (apply),
        .cfg_ready  (cfg_ready),
        .pending    (pending),
        .shadow_half(shadow_half)
    );

    // half_q is never zero, so the subtraction cannot wrap.
    assign terminal = (cnt_q == half_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        apply   = 1'b0;
        unique case (state_q)
            StStop: begin
                cnt_d = '0;
                apply = pending;
                if (en) state_d = StRunLo;
            end
            StRunLo: begin
                if (terminal) begin
                    cnt_d   = '0;
                    state_d = StRunHi;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRunHi: begin
                if (terminal) begin
                    cnt_d   = '0;
                    state_d = StRunLo;
                    apply   = pending;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StStop;
            end
        endcase
        // Dropping en parks the output low at once; STOP applies any pending update later.
        if (!en && state_q != StStop) begin
            state_d = StStop;
            cnt_d   = '0;
            apply   = 1'b0;
        end
        if (apply) half_d = shadow_half;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q   <= StStop;
            cnt_q     <= '0;
            half_q    <= CNT_W'(DEF_HALF);
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            clk_out_q <= (state_d == StRunHi);
        end
    end

    assign clk_out = clk_out_q;

`ifdef CLK_DIV_TICK_EN
    logic tick_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= (state_q == StRunLo) && (state_d == StRunHi);
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with DEF_HALF = 5; tick checks build when CLK_DIV_TICK_EN is set.
module tb_clk_div_prog;

    localparam int unsigned CW = 23;

    logic          clk_100MHz = 1'b0;
    logic          reset;
    logic          en;
    logic          cfg_valid;
    logic [CW-1:0] cfg_half;
    logic          cfg_ready;
    logic          clk_out;
    logic          pending;
`ifdef CLK_DIV_TICK_EN
    logic          tick;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int len;

    clk_div_prog #(
        .CNT_W   (CW),
        .DEF_HALF(5)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .pending   (pending)
`ifdef CLK_DIV_TICK_EN
        ,
        .tick      (tick)
`endif
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Count consecutive sampled cycles at the given level; bounded so a stuck output fails.
    task automatic measure(input logic level, output int n);
        n = 0;
        while (clk_out === level && n < 64) begin
            n++;
            cyc();
        end
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        #2;
        chk("reset_clk_out", clk_out, 0);
        chk("reset_pending", pending, 0);
        chk("reset_ready", cfg_ready, 1);
`ifdef CLK_DIV_TICK_EN
        chk("reset_tick", tick, 0);
`endif
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("stop_idle_clk_out", clk_out, 0);

        // Default 5/5 run
        en = 1'b1;
        cyc();
        measure(1'b0, len); chk("run5_first_lo", len, 5);
        measure(1'b1, len); chk("run5_hi_a", len, 5);
        measure(1'b0, len); chk("run5_lo_b", len, 5);
        measure(1'b1, len); chk("run5_hi_b", len, 5);
        measure(1'b0, len); chk("run5_lo_c", len, 5);

        // en dropped on the second cycle of RUN_HI
        cyc();
        chk("endrop_hi2", clk_out, 1);
        en = 1'b0;
        cyc();
        chk("endrop_clk_out", clk_out, 0);
        chk("endrop_cnt", dut.cnt_q, 0);
        cyc();
        chk("endrop_park", clk_out, 0);
        en = 1'b1;
        cyc();
        measure(1'b0, len); chk("reen_lo", len, 5);
        measure(1'b1, len); chk("reen_hi", len, 5);

        // Update to 3 offered at start of RUN_LO; a second offer while pending is ignored
        cfg_valid = 1'b1;
        cfg_half  = CW'(3);
        chk("upd_ready_before", cfg_ready, 1);
        cyc();
        cfg_valid = 1'b0;
        chk("upd_pending_set", pending, 1);
        chk("upd_ready_low", cfg_ready, 0);
        measure(1'b0, len); chk("upd_old_lo_rest", len, 4);
        for (int i = 0; i < 5; i++) begin
            chk("upd_old_hi", clk_out, 1);
            chk("upd_hold_pending", pending, 1);
            chk("upd_hold_ready", cfg_ready, 0);
            if (i == 1) begin
                cfg_valid = 1'b1;
                cfg_half  = CW'(9);
            end
            if (i == 2) cfg_valid = 1'b0;
            cyc();
        end
        chk("upd_fall_clk_out", clk_out, 0);
        chk("upd_fall_pending", pending, 0);
        chk("upd_fall_ready", cfg_ready, 1);
        measure(1'b0, len); chk("run3_lo_a", len, 3);
        measure(1'b1, len); chk("run3_hi_a", len, 3);
        measure(1'b0, len); chk("run3_lo_b", len, 3);
        measure(1'b1, len); chk("run3_hi_b", len, 3);

        // Reset mid-RUN_HI with an update to 7 pending
        cfg_valid = 1'b1;
        cfg_half  = CW'(7);
        cyc();
        cfg_valid = 1'b0;
        chk("rst_pending_set", pending, 1);
        measure(1'b0, len); chk("rst_lo_rest", len, 2);
        cyc();
        chk("rst_mid_hi", clk_out, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_clk_out", clk_out, 0);
        chk("rst_async_pending", pending, 0);
        chk("rst_async_ready", cfg_ready, 1);
        cyc();
        reset = 1'b0;
        cyc();
        measure(1'b0, len); chk("rst_after_lo", len, 5);
        measure(1'b1, len); chk("rst_after_hi", len, 5);
        chk("rst_after_pending", pending, 0);

        // cfg_half = 0 while stopped clamps to 1
        en = 1'b0;
        cyc();
        chk("zero_stop", clk_out, 0);
        cfg_valid = 1'b1;
        cfg_half  = '0;
        cyc();
        cfg_valid = 1'b0;
        chk("zero_pending_set", pending, 1);
        chk("zero_ready_low", cfg_ready, 0);
        cyc();
        chk("zero_applied", pending, 0);
        en = 1'b1;
        cyc();
        measure(1'b0, len); chk("run1_lo_a", len, 1);
        measure(1'b1, len); chk("run1_hi_a", len, 1);
        measure(1'b0, len); chk("run1_lo_b", len, 1);
        measure(1'b1, len); chk("run1_hi_b", len, 1);

`ifdef CLK_DIV_TICK_EN
        begin
            logic prev;
            int   n_tick;
            int   n_rise;
            prev   = clk_out;
            n_tick = 0;
            n_rise = 0;
            for (int i = 0; i < 100; i++) begin
                cyc();
                chk("tick_coincident", tick, (clk_out && !prev) ? 1 : 0);
                if (tick === 1'b1) n_tick++;
                if (clk_out && !prev) n_rise++;
                prev = clk_out;
            end
            chk("tick_count", n_tick, 50);
            chk("rise_count", n_rise, 50);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
